// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Also holds the address helper used by the top level.
package imem_loader_pkg;

  typedef enum logic [2:0] {IDLE, HDR, DATA, DONE, ERR} ldr_state_t;

  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;

  // Word k lands at base + 4k, wrapping modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in (valid/ready) and instruction-memory write port out.
// A byte transfers on a rising edge where rx_valid && rx_ready. rx_valid and rx_data may
// be held across cycles and need not wait for rx_ready. we is a one-cycle strobe that
// qualifies Instrucoes/ADDR_INST and has no back-pressure.
interface imem_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        we;
  logic [31:0] Instrucoes;
  logic [31:0] ADDR_INST;

  modport slave  (input rx_valid, rx_data, output rx_ready, we, Instrucoes, ADDR_INST);
  modport master (output rx_valid, rx_data, input rx_ready, we, Instrucoes, ADDR_INST);
endinterface

// File: rtl/imem_loader_byte_packer.sv
// 8->32 little-endian assembler: byte 0 of each group lands in word[7:0].
// word_valid pulses for one cycle after the 4th byte; word holds until the next group completes.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] part;
  logic [1:0]  cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      part       <= '0;
      cnt        <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else if (clr) begin
      part       <= '0;
      cnt        <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (in_valid) begin
        if (cnt == 2'(WORD_BYTES - 1)) begin
          word       <= {in_data, part};
          word_valid <= 1'b1;
          cnt        <= '0;
        end else begin
          part <= {in_data, part[23:8]};
          cnt  <= cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a framed byte image (word count N, then N words) into instruction memory,
// holding the core in reset until the image is complete.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          TIMEOUT_CYC = 100000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          core_hold,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [15:0]   words_loaded,
  output ldr_state_t    dbg_state
);

  ldr_state_t  state;
  logic [1:0]  byte_cnt;
  logic [31:0] word_cnt;
  logic [31:0] n_words;
  logic [31:0] to_cnt;
  logic        rx_ready_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic        acc;
  logic        start_ok;
  logic        pk_valid;
  logic [31:0] pk_word;

  assign acc      = bus.rx_valid && rx_ready_q;
  assign start_ok = start && (state == IDLE || state == DONE || state == ERR);

  // Instrucoes comes straight from the packer's word register, so the write
  // lands one cycle after the last byte while the packer keeps accepting.
  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (start_ok),
    .in_valid   (acc),
    .in_data    (bus.rx_data),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

  assign bus.rx_ready   = rx_ready_q;
  assign bus.we         = we_q;
  assign bus.Instrucoes = pk_word;
  assign bus.ADDR_INST  = addr_q;
  assign dbg_state      = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      byte_cnt     <= '0;
      word_cnt     <= '0;
      n_words      <= '0;
      to_cnt       <= '0;
      rx_ready_q   <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= BASE_ADDR;
      core_hold    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      we_q <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= HDR;
            byte_cnt     <= '0;
            word_cnt     <= '0;
            n_words      <= '0;
            to_cnt       <= '0;
            rx_ready_q   <= 1'b1;
            core_hold    <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
          end
        end
        HDR, DATA: begin
          if (acc) begin
            to_cnt   <= '0;
            byte_cnt <= byte_cnt + 2'd1;
          end else begin
            to_cnt <= to_cnt + 32'd1;
          end
          // Stop taking bytes while the header is being judged.
          if (state == HDR && acc && byte_cnt == 2'(HDR_BYTES - 1))
            rx_ready_q <= 1'b0;
          if (state == DATA && acc && byte_cnt == 2'(WORD_BYTES - 1)) begin
            we_q     <= 1'b1;
            addr_q   <= word_addr(BASE_ADDR, word_cnt);
            word_cnt <= word_cnt + 32'd1;
            if (words_loaded != 16'hFFFF)
              words_loaded <= words_loaded + 16'd1;
            if (word_cnt + 32'd1 == n_words)
              rx_ready_q <= 1'b0;
          end
          if (state == HDR && pk_valid) begin
            n_words <= pk_word;
            if (pk_word == 32'd0) begin
              state      <= DONE;
              rx_ready_q <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              core_hold  <= 1'b0;
            end else if (pk_word > 32'(DEPTH_WORDS)) begin
              state      <= ERR;
              rx_ready_q <= 1'b0;
              busy       <= 1'b0;
              err        <= 1'b1;
              core_hold  <= 1'b1;
            end else begin
              state      <= DATA;
              rx_ready_q <= 1'b1;
            end
          end else if (state == DATA && we_q && word_cnt == n_words) begin
            state      <= DONE;
            rx_ready_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            core_hold  <= 1'b0;
          end else if (!acc && to_cnt == 32'(TIMEOUT_CYC - 1)) begin
            state      <= ERR;
            rx_ready_q <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b1;
            core_hold  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench: two loaders (base 0x0 and 0x1000, timeout 16) fed the same byte stream,
// with a write scoreboard checking every memory write against hand-computed words.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       rx_valid;
  logic [7:0] rx_data;

  imem_loader_if bus_a ();
  imem_loader_if bus_b ();
  assign bus_a.rx_valid = rx_valid;
  assign bus_a.rx_data  = rx_data;
  assign bus_b.rx_valid = rx_valid;
  assign bus_b.rx_data  = rx_data;

  logic        hold_a, busy_a, done_a, err_a;
  logic        hold_b, busy_b, done_b, err_b;
  logic [15:0] wl_a, wl_b;
  ldr_state_t  st_a, st_b;

  imem_loader #(.BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(256), .TIMEOUT_CYC(16)) dut_a (
    .clk(clk), .rst(rst), .start(start), .bus(bus_a), .core_hold(hold_a), .busy(busy_a),
    .done(done_a), .err(err_a), .words_loaded(wl_a), .dbg_state(st_a));

  imem_loader #(.BASE_ADDR(32'h0000_1000), .DEPTH_WORDS(256), .TIMEOUT_CYC(16)) dut_b (
    .clk(clk), .rst(rst), .start(start), .bus(bus_b), .core_hold(hold_b), .busy(busy_b),
    .done(done_b), .err(err_b), .words_loaded(wl_b), .dbg_state(st_b));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [63:0] exp_qa[$];
  logic [63:0] exp_qb[$];
  logic        chk_gap = 1'b0;
  logic        wr_seen = 1'b0;
  int unsigned last_we = 0;

  task automatic expect_write(input logic [31:0] k, input logic [31:0] data);
    exp_qa.push_back({32'h0000_0000 + (k << 2), data});
    exp_qb.push_back({32'h0000_1000 + (k << 2), data});
  endtask

  always @(negedge clk) begin
    logic [63:0] e;
    if (bus_a.we) begin
      if (exp_qa.size() == 0) check("unexp_we_a", {31'd0, bus_a.we}, 32'd0);
      else begin
        e = exp_qa.pop_front();
        check("wr_addr_a", bus_a.ADDR_INST, e[63:32]);
        check("wr_data_a", bus_a.Instrucoes, e[31:0]);
        if (chk_gap && wr_seen) check("we_gap", cyc - last_we, 32'd4);
        last_we = cyc;
        wr_seen = 1'b1;
      end
    end
    if (bus_b.we) begin
      if (exp_qb.size() == 0) check("unexp_we_b", {31'd0, bus_b.we}, 32'd0);
      else begin
        e = exp_qb.pop_front();
        check("wr_addr_b", bus_b.ADDR_INST, e[63:32]);
        check("wr_data_b", bus_b.Instrucoes, e[31:0]);
      end
    end
  end

  // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
  task automatic send_byte(input logic [7:0] b);
    int i;
    rx_valid = 1'b1;
    rx_data  = b;
    for (i = 0; i < 50; i++) begin
      if (bus_a.rx_ready) break;
      @(negedge clk);
    end
    if (i == 50) check("rdy_timeout", {31'd0, bus_a.rx_ready}, 32'd1);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(8'((w >> (8 * i)) & 32'hFF));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_done(input string tag, input logic [15:0] wl);
    check({tag, "_done"}, {31'd0, done_a}, 32'd1);
    check({tag, "_hold"}, {31'd0, hold_a}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
    check({tag, "_wl"}, {16'd0, wl_a}, {16'd0, wl});
    check({tag, "_done_b"}, {31'd0, done_b}, 32'd1);
    check({tag, "_qempty"}, exp_qa.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    // reset state
    check("rst_state", 32'(st_a), 32'(IDLE));
    check("rst_hold", {31'd0, hold_a}, 32'd1);
    check("rst_ready", {31'd0, bus_a.rx_ready}, 32'd0);
    check("rst_we", {31'd0, bus_a.we}, 32'd0);
    check("rst_addr_a", bus_a.ADDR_INST, 32'h0000_0000);
    check("rst_addr_b", bus_b.ADDR_INST, 32'h0000_1000);
    check("rst_instr", bus_a.Instrucoes, 32'd0);
    check("rst_flags", {29'd0, busy_a, done_a, err_a}, 32'd0);
    check("rst_wl", {16'd0, wl_a}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: two-word image
    pulse_start();
    check("t1_busy", {31'd0, busy_a}, 32'd1);
    check("t1_ready", {31'd0, bus_a.rx_ready}, 32'd1);
    expect_write(0, 32'h0000_0013);
    expect_write(1, 32'h0010_0093);
    send_word(32'd2);
    send_word(32'h0000_0013);
    send_word(32'h0010_0093);
    rx_valid = 1'b0;
    check("t1_lat_we", {31'd0, bus_a.we}, 32'd1);
    check("t1_hold_at_we", {31'd0, hold_a}, 32'd1);
    @(negedge clk);
    check_done("t1", 16'd2);

    // 2: empty image
    pulse_start();
    send_word(32'd0);
    rx_valid = 1'b0;
    check("t2_pre_done", {31'd0, done_a}, 32'd0);
    check("t2_pre_ready", {31'd0, bus_a.rx_ready}, 32'd0);
    @(negedge clk);
    check("t2_state", 32'(st_a), 32'(DONE));
    check_done("t2", 16'd0);

    // 3: oversize header, stray bytes must not be taken
    pulse_start();
    send_word(32'd257);
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    @(negedge clk);
    check("t3_err", {31'd0, err_a}, 32'd1);
    check("t3_hold", {31'd0, hold_a}, 32'd1);
    check("t3_ready", {31'd0, bus_a.rx_ready}, 32'd0);
    check("t3_state", 32'(st_a), 32'(ERR));
    idle(3);
    check("t3_still_err", {31'd0, err_a}, 32'd1);
    check("t3_wl", {16'd0, wl_a}, 32'd0);

    // N == DEPTH_WORDS is accepted
    pulse_start();
    send_word(32'd256);
    rx_valid = 1'b0;
    @(negedge clk);
    check("t3b_state", 32'(st_a), 32'(DATA));
    check("t3b_err", {31'd0, err_a}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 4: stall after two data bytes
    pulse_start();
    send_word(32'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    idle(15);
    check("t4_no_err_yet", {31'd0, err_a}, 32'd0);
    @(negedge clk);
    check("t4_err", {31'd0, err_a}, 32'd1);
    check("t4_hold", {31'd0, hold_a}, 32'd1);
    check("t4_ready", {31'd0, bus_a.rx_ready}, 32'd0);
    check("t4_wl", {16'd0, wl_a}, 32'd0);

    // 5: reset mid-word, then a clean reload
    pulse_start();
    expect_write(0, 32'h0403_0201);
    send_word(32'd4);
    send_word(32'h0403_0201);
    send_byte(8'h05);
    send_byte(8'h06);
    rst = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    check("t5_state", 32'(st_a), 32'(IDLE));
    check("t5_wl", {16'd0, wl_a}, 32'd0);
    check("t5_hold", {31'd0, hold_a}, 32'd1);
    check("t5_ready", {31'd0, bus_a.rx_ready}, 32'd0);
    check("t5_instr", bus_a.Instrucoes, 32'd0);
    check("t5_addr", bus_a.ADDR_INST, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    pulse_start();
    expect_write(0, 32'h1234_5678);
    send_word(32'd1);
    send_word(32'h1234_5678);
    rx_valid = 1'b0;
    @(negedge clk);
    check_done("t5", 16'd1);

    // 6: back-to-back data, with a start pulse that must be ignored
    pulse_start();
    send_word(32'd2);
    expect_write(0, 32'h4433_2211);
    expect_write(1, 32'h8877_6655);
    chk_gap = 1'b1;
    wr_seen = 1'b0;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    start = 1'b1;
    send_byte(8'h55);
    start = 1'b0;
    send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    rx_valid = 1'b0;
    @(negedge clk);
    chk_gap = 1'b0;
    check_done("t6", 16'd2);
    check("t6_wl_b", {16'd0, wl_b}, 32'd2);
    check("t6_qempty_b", exp_qb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
